inst_fetch: RTL
===============

Name: inst_fetch

Overview:
- Producer end of the instruction path: fetches 2-byte instructions (opcode byte, operand byte) from synchronous program memory and presents them to the decode/execute stage through a valid/ready handshake.
- Owns the program counter and applies jump redirects from execute.
- Sits between program ROM and the decode block. Its opcode output feeds the decode block's instruction input directly.

Parameters:
- ADDR_W, 8, program memory address width and PC width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- _iClk  in  1  clock, rising-edge.
- _iReset_n  in  1  asynchronous active-low reset.
- _oMemAddr  out  ADDR_W  program memory byte address.
- _oMemRd  out  1  memory read strobe. Data returns on _iMemData exactly 1 cycle later.
- _iMemData  in  8  memory read data.
- _oInst  out  8  opcode byte, to the decode block.
- _oOperand  out  8  operand byte (immediate or address).
- _oPC  out  ADDR_W  address of the opcode byte of the presented instruction.
- _oInstValid  out  1  _oInst/_oOperand/_oPC are valid.
- _iInstReady  in  1  execute accepts the instruction this cycle.
- _iJump  in  1  redirect request.
- _iJumpAddr  in  ADDR_W  redirect target.

Behaviour:
- Reset (async assert, sync release):
  - PC=RESET_PC, state=S_OP_REQ.
  - _oInstValid=0, _oInst=0, _oOperand=0, _oPC=RESET_PC, _oMemRd=0, _oMemAddr=RESET_PC.
- Reset mid-fetch discards everything; fetch restarts from RESET_PC.
- FSM, one state per cycle:
  - S_OP_REQ: _oMemRd=1, _oMemAddr=PC. Next state S_ARG_REQ.
  - S_ARG_REQ: _oMemRd=1, _oMemAddr=PC+1 (mod 2^ADDR_W). Register _iMemData into the opcode register. Next state S_ARG_WAIT.
  - S_ARG_WAIT: _oMemRd=0. Register _iMemData into the operand register. Next state S_VALID.
  - S_VALID: _oInstValid=1, outputs stable, _oMemRd=0.
    - If _iInstReady: PC<=PC+2 (mod 2^ADDR_W), next state S_OP_REQ.
    - Otherwise hold indefinitely with no output change.
- _oInstValid is registered. It is 1 only in S_VALID.
- Latency: first valid 3 cycles after the first S_OP_REQ cycle. Throughput: 1 instruction per 4 cycles with ready held high.
- Handshake:
  - Transfer occurs when _oInstValid && _iInstReady on a rising edge.
  - _iInstReady is ignored when _oInstValid=0.
  - Once valid is asserted, outputs must not change until transfer or jump.
- Jump:
  - _iJump is sampled in every state and has highest priority.
  - On the next edge: PC<=_iJumpAddr, state<=S_OP_REQ, _oInstValid<=0.
  - Read data still in flight is discarded; the opcode/operand registers may hold stale values while valid=0.
- _iJump with _iInstReady in S_VALID: the jump wins, and PC becomes _iJumpAddr, not PC+2.
- _iJump asserted for multiple cycles: the last asserted cycle's address wins. Fetch begins the cycle after _iJump deasserts.
- Wrap-around:
  - PC+1 and PC+2 wrap modulo 2^ADDR_W.
  - Odd jump targets are legal; the operand is read from target+1 with wrap.
- The block does not validate opcodes; invalid opcodes are flagged by the decode block.

Test Plan:
- Sequential fetch:
  - Stimulus: ROM[0..5]=01,AA,02,BB,03,CC; ready held 1.
  - Required: (Inst,Operand,PC) = (01,AA,00), (02,BB,02), (03,CC,04). Valid high 1 cycle each, 4-cycle spacing, first valid 3 cycles after the first S_OP_REQ cycle.
- Backpressure:
  - Stimulus: ready=0 for 10 cycles while valid.
  - Required: outputs held at (01,AA,00), _oMemRd=0 throughout. Ready=1 for one cycle, then the next fetch starts at address 02.
- Jump with ready:
  - Stimulus: in S_VALID at PC=02, drive _iJump=1, _iJumpAddr=40, ready=1; ROM[40]=11, ROM[41]=77.
  - Required: valid drops next cycle, _oMemAddr=40 next cycle, then (11,77,40) presented.
- Jump mid-fetch:
  - Stimulus: assert _iJump (addr=80) in the S_ARG_REQ cycle of the fetch at 00.
  - Required: the instruction at 00 is never presented; the next valid is (ROM[80],ROM[81],80).
- Wrap:
  - Stimulus: ADDR_W=8, jump to FF; ROM[FF]=05, ROM[00]=09.
  - Required: presents (05,09,FF); after accept, the next fetch is at 01.
- Reset mid-operation:
  - Stimulus: assert _iReset_n=0 asynchronously between edges while in S_VALID.
  - Required: valid=0 and _oMemRd=0 immediately (no clock edge); after release, the first fetch is at RESET_PC.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: fetches 2-byte instructions (opcode, operand) from synchronous
// program memory and presents them to decode/execute with a valid/ready
// handshake. Owns the PC and applies jump redirects from execute.
module inst_fetch #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic              _iClk,
  input  logic              _iReset_n,
  output logic [ADDR_W-1:0] _oMemAddr,
  output logic              _oMemRd,
  input  logic [7:0]        _iMemData,
  output logic [7:0]        _oInst,
  output logic [7:0]        _oOperand,
  output logic [ADDR_W-1:0] _oPC,
  output logic              _oInstValid,
  input  logic              _iInstReady,
  input  logic              _iJump,
  input  logic [ADDR_W-1:0] _iJumpAddr
);

  localparam int unsigned DataW = 8;
  localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

  // One state per cycle: opcode request, operand request, operand landing, present.
  typedef enum logic [1:0] {
    S_OP_REQ   = 2'd0,
    S_ARG_REQ  = 2'd1,
    S_ARG_WAIT = 2'd2,
    S_VALID    = 2'd3
  } state_t;

  state_t            state;
  state_t            nextState;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] nextPc;
  logic              started;
  logic [DataW-1:0]  inst;
  logic [DataW-1:0]  nextInst;
  logic [DataW-1:0]  operand;
  logic [DataW-1:0]  nextOperand;
  logic [ADDR_W-1:0] memAddr;
  logic [ADDR_W-1:0] nextMemAddr;
  logic              memRd;
  logic              nextMemRd;
  logic              instValid;
  logic              nextInstValid;

  // Next phase, PC and datapath loads; outputs are decoded from the phase being
  // entered so that every output comes straight from a flop.
  // The first edge after reset release re-enters S_OP_REQ so the read strobe
  // (held low in reset) is raised for a full S_OP_REQ cycle.
  always_comb begin
    nextState     = state;
    nextPc        = pc;
    nextInst      = inst;
    nextOperand   = operand;
    nextMemAddr   = memAddr;
    nextMemRd     = 1'b0;
    nextInstValid = 1'b0;

    if (_iJump) begin
      // Jump has top priority in every phase; in-flight read data is dropped.
      nextState = S_OP_REQ;
      nextPc    = _iJumpAddr;
    end else if (!started) begin
      nextState = S_OP_REQ;
    end else begin
      case (state)
        S_OP_REQ: begin
          nextState = S_ARG_REQ;
        end
        S_ARG_REQ: begin
          nextState = S_ARG_WAIT;
          nextInst  = _iMemData;
        end
        S_ARG_WAIT: begin
          nextState   = S_VALID;
          nextOperand = _iMemData;
        end
        S_VALID: begin
          if (_iInstReady) begin
            nextState = S_OP_REQ;
            nextPc    = pc + ADDR_W'(2);
          end
        end
        default: begin
          nextState = S_OP_REQ;
        end
      endcase
    end

    case (nextState)
      S_OP_REQ: begin
        nextMemRd   = 1'b1;
        nextMemAddr = nextPc;
      end
      S_ARG_REQ: begin
        nextMemRd   = 1'b1;
        nextMemAddr = nextPc + ADDR_W'(1);
      end
      S_VALID: begin
        nextInstValid = 1'b1;
      end
      default: begin
        nextMemRd = 1'b0;
      end
    endcase
  end

  // Phase, PC, instruction registers and all outputs advance together.
  always_ff @(posedge _iClk or negedge _iReset_n) begin
    if (!_iReset_n) begin
      state     <= S_OP_REQ;
      pc        <= ResetPc;
      started   <= 1'b0;
      inst      <= '0;
      operand   <= '0;
      memAddr   <= ResetPc;
      memRd     <= 1'b0;
      instValid <= 1'b0;
    end else begin
      state     <= nextState;
      pc        <= nextPc;
      started   <= 1'b1;
      inst      <= nextInst;
      operand   <= nextOperand;
      memAddr   <= nextMemAddr;
      memRd     <= nextMemRd;
      instValid <= nextInstValid;
    end
  end

  assign _oMemAddr   = memAddr;
  assign _oMemRd     = memRd;
  assign _oInst      = inst;
  assign _oOperand   = operand;
  assign _oPC        = pc;
  assign _oInstValid = instValid;

endmodule
